// File: rtl/uart_word_tx.sv
// uart_word_tx: frames a WIDTH-bit status word into bytes for a uart_tx byte transmitter.
// A frame is sent whenever the word differs from the last completed frame, or on a
// force_send pulse while idle. Changes arriving mid-frame are coalesced: only the latest
// value is sent afterwards, and a second superseded change raises the sticky overrun flag.
// The resend request is called force_send because "force" is a reserved word.
module uart_word_tx #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned HEADER_EN   = 0,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             force_send,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned NBYTES    = (WIDTH + 7) / 8;
  localparam int unsigned FRAME_LEN = NBYTES + HEADER_EN;
  localparam int unsigned PADW      = NBYTES * 8;
  localparam logic [2:0]  LAST_IDX  = 3'(FRAME_LEN - 1);
  localparam logic [2:0]  HDR_OFS   = 3'(HEADER_EN);
  localparam logic [7:0]  TO_LAST   = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StAck, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] last_sent_q, last_sent_d;
  logic [WIDTH-1:0] value_q;
  logic             chg_pend_q, chg_pend_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             overrun_q, overrun_d;

  logic [PADW-1:0]  padded;
  logic [2:0]       data_idx;
  logic [7:0]       cur_byte;

  // Select the byte for the current index: optional header, then zero-padded word MSB first.
  always_comb begin
    padded   = PADW'(snap_q);
    data_idx = idx_q - HDR_OFS;
    cur_byte = 8'h00;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (data_idx == 3'(NBYTES - 1 - b)) begin
        cur_byte = padded[b*8 +: 8];
      end
    end
    if (HEADER_EN != 0 && idx_q == 3'd0) begin
      cur_byte = HEADER;
    end
  end

  // Next-state logic for the framer FSM, the change coalescing and the registered outputs.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    last_sent_d = last_sent_q;
    chg_pend_d  = chg_pend_q;
    idx_d       = idx_q;
    to_cnt_d    = to_cnt_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    overrun_d   = overrun_q;

    // The retrigger on return to idle sends the newest value; a second change lost one.
    if (state_q != StIdle && value != value_q) begin
      if (chg_pend_q) begin
        overrun_d = 1'b1;
      end
      chg_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (value != last_sent_q || force_send) begin
          snap_d     = value;
          idx_d      = 3'd0;
          chg_pend_d = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          to_cnt_d   = 8'd0;
          state_d    = StAck;
        end
      end
      StAck: begin
        // A transmitter that never shows busy is treated as having accepted the byte.
        if (tx_busy || to_cnt_q == TO_LAST) begin
          state_d = StDrain;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      StDrain: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            last_sent_d = snap_q;
            state_d     = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StStart;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      snap_q      <= '0;
      last_sent_q <= '0;
      value_q     <= '0;
      chg_pend_q  <= 1'b0;
      idx_q       <= 3'd0;
      to_cnt_q    <= 8'd0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      last_sent_q <= last_sent_d;
      value_q     <= value;
      chg_pend_q  <= chg_pend_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != StIdle);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: two instances (10-bit plain, 24-bit with header), each
// driven by a small uart_tx model that stays busy for 20 cycles per accepted byte.
module tb_uart_word_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: WIDTH=10, no header
  logic [9:0]  value_a;
  logic        force_a;
  logic        tx_busy_a, tx_start_a, busy_a, overrun_a;
  logic [7:0]  tx_data_a;

  // Instance B: WIDTH=24, header enabled
  logic [23:0] value_b;
  logic        force_b;
  logic        tx_busy_b, tx_start_b, busy_b, overrun_b;
  logic [7:0]  tx_data_b;

  uart_word_tx #(.WIDTH(10), .HEADER_EN(0), .HEADER(8'hA5), .ACK_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .value(value_a), .force_send(force_a), .tx_busy(tx_busy_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .busy(busy_a), .overrun(overrun_a)
  );

  uart_word_tx #(.WIDTH(24), .HEADER_EN(1), .HEADER(8'hA5), .ACK_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .value(value_b), .force_send(force_b), .tx_busy(tx_busy_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .busy(busy_b), .overrun(overrun_b)
  );

  // uart_tx models: record bytes, flag start pulses that overlap busy or repeat.
  int         cnt_a = 0, cnt_b = 0;
  bit         hold_a = 1'b0, nobusy_a = 1'b0;
  bit         prev_a = 1'b0, prev_b = 1'b0;
  int         viol_a = 0, viol_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  assign tx_busy_a = hold_a | (cnt_a != 0);
  assign tx_busy_b = (cnt_b != 0);

  always @(posedge clk) begin
    prev_a <= tx_start_a;
    if (tx_start_a) begin
      q_a.push_back(tx_data_a);
      if (tx_busy_a || prev_a) viol_a <= viol_a + 1;
      if (!nobusy_a) cnt_a <= 20;
    end else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1;
    end
  end

  always @(posedge clk) begin
    prev_b <= tx_start_b;
    if (tx_start_b) begin
      q_b.push_back(tx_data_b);
      if (tx_busy_b || prev_b) viol_b <= viol_b + 1;
      cnt_b <= 20;
    end else if (cnt_b != 0) begin
      cnt_b <= cnt_b - 1;
    end
  end

  function automatic string q_str(input logic [7:0] q[$]);
    string s;
    s = $sformatf("n=%0d:", q.size());
    foreach (q[i]) if (i < 8) s = {s, $sformatf(" %02h", q[i])};
    return s;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_a) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_qa(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q_a.size() >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_force_a();
    force_a = 1'b1;
    tick(1);
    force_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; value_a = '0; value_b = '0; force_a = 1'b0; force_b = 1'b0;
    tick(3);
    checks++;
    if (tx_start_a !== 1'b0 || tx_data_a !== 8'h00 || busy_a !== 1'b0 || overrun_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: start=%b data=%02h busy=%b ovr=%b, required 0 00 0 0",
               tx_start_a, tx_data_a, busy_a, overrun_a);
    end
    checks++;
    if (tx_start_b !== 1'b0 || busy_b !== 1'b0 || overrun_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: start=%b busy=%b ovr=%b, required 0 0 0",
               tx_start_b, busy_b, overrun_b);
    end
    rst = 1'b0;
    tick(10);
    checks++;
    if (q_a.size() !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: bytes %s busy=%b, required none and idle", q_str(q_a), busy_a);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    value_a = 10'h2AB;
    tick(1);
    checks++;
    if (busy_a !== 1'b1 || tx_start_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_capture: busy=%b start=%b, required 1 0", busy_a, tx_start_a);
    end
    tick(1);
    checks++;
    if (tx_start_a !== 1'b1 || tx_data_a !== 8'h02) begin
      errors++;
      $display("FAIL basic_first_start: start=%b data=%02h, required 1 02", tx_start_a, tx_data_a);
    end
    tick(1);
    checks++;
    if (tx_start_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: start=%b, required 0", tx_start_a);
    end
    wait_idle_a(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: busy=%b after 200 cycles, required 0", busy_a);
    end
    tick(30);
    checks++;
    if (q_a.size() !== 2 || q_a[0] !== 8'h02 || q_a[1] !== 8'hAB || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_bytes: got %s busy=%b, required 02 AB busy=0", q_str(q_a), busy_a);
    end
  endtask

  task automatic test_header();
    int i;
    value_b = 24'h123456;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_b.size() >= 4 && !busy_b) break;
    end
    tick(30);
    checks++;
    if (q_b.size() !== 4 || q_b[0] !== 8'hA5 || q_b[1] !== 8'h12 || q_b[2] !== 8'h34 ||
        q_b[3] !== 8'h56) begin
      errors++;
      $display("FAIL header_bytes: got %s, required A5 12 34 56", q_str(q_b));
    end
    checks++;
    if (overrun_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL header_flags: ovr=%b busy=%b, required 0 0", overrun_b, busy_b);
    end
  endtask

  task automatic test_force();
    bit ok;
    q_a.delete();
    tick(5);
    checks++;
    if (q_a.size() !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL force_quiet: got %s busy=%b, required none", q_str(q_a), busy_a);
    end
    pulse_force_a();
    tick(1);
    wait_idle_a(200, ok);
    checks++;
    if (!ok || q_a.size() !== 2 || q_a[0] !== 8'h02 || q_a[1] !== 8'hAB) begin
      errors++;
      $display("FAIL force_resend: got %s ok=%b, required 02 AB", q_str(q_a), ok);
    end
    q_a.delete();
    pulse_force_a();
    tick(10);
    pulse_force_a();
    tick(1);
    wait_idle_a(200, ok);
    tick(30);
    checks++;
    if (!ok || q_a.size() !== 2 || q_a[0] !== 8'h02 || q_a[1] !== 8'hAB) begin
      errors++;
      $display("FAIL force_midframe: got %s ok=%b, required only 02 AB", q_str(q_a), ok);
    end
  endtask

  task automatic test_coalesce();
    bit ok;
    checks++;
    if (overrun_a !== 1'b0) begin
      errors++;
      $display("FAIL coalesce_pre_ovr: ovr=%b, required 0", overrun_a);
    end
    q_a.delete();
    pulse_force_a();
    wait_qa(1, 50, ok);
    value_a = 10'h001;
    tick(1);
    checks++;
    if (!ok || overrun_a !== 1'b0) begin
      errors++;
      $display("FAIL coalesce_first_change: ok=%b ovr=%b, required 1 0", ok, overrun_a);
    end
    value_a = 10'h002;
    tick(1);
    checks++;
    if (overrun_a !== 1'b1) begin
      errors++;
      $display("FAIL coalesce_second_change: ovr=%b, required 1", overrun_a);
    end
    value_a = 10'h003;
    wait_qa(4, 400, ok);
    wait_idle_a(200, ok);
    tick(30);
    checks++;
    if (q_a.size() !== 4 || q_a[0] !== 8'h02 || q_a[1] !== 8'hAB || q_a[2] !== 8'h00 ||
        q_a[3] !== 8'h03) begin
      errors++;
      $display("FAIL coalesce_bytes: got %s, required 02 AB 00 03", q_str(q_a));
    end
    checks++;
    if (overrun_a !== 1'b1) begin
      errors++;
      $display("FAIL coalesce_sticky: ovr=%b, required 1", overrun_a);
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int starts;
    q_a.delete();
    hold_a = 1'b1;
    value_a = 10'h155;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start_a) starts++;
    end
    checks++;
    if (starts !== 0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL hold_no_start: starts=%0d busy=%b, required 0 1", starts, busy_a);
    end
    hold_a = 1'b0;
    wait_qa(2, 200, ok);
    wait_idle_a(200, ok);
    checks++;
    if (q_a.size() !== 2 || q_a[0] !== 8'h01 || q_a[1] !== 8'h55) begin
      errors++;
      $display("FAIL hold_bytes: got %s, required 01 55", q_str(q_a));
    end
  endtask

  task automatic test_ack_timeout();
    bit ok;
    q_a.delete();
    nobusy_a = 1'b1;
    value_a = 10'h3C0;
    tick(1);
    wait_idle_a(40, ok);
    checks++;
    if (!ok || q_a.size() !== 2 || q_a[0] !== 8'h03 || q_a[1] !== 8'hC0) begin
      errors++;
      $display("FAIL timeout_frame: got %s idle=%b, required 03 C0 within 40", q_str(q_a), ok);
    end
    nobusy_a = 1'b0;
    tick(5);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    q_a.delete();
    value_a = 10'h2AB;
    wait_qa(1, 50, ok);
    tick(5);
    q_a.delete();
    rst = 1'b1;
    tick(1);
    checks++;
    if (busy_a !== 1'b0 || tx_start_a !== 1'b0 || overrun_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b start=%b ovr=%b, required 0 0 0",
               busy_a, tx_start_a, overrun_a);
    end
    rst = 1'b0;
    wait_qa(2, 300, ok);
    wait_idle_a(200, ok);
    checks++;
    if (q_a.size() !== 2 || q_a[0] !== 8'h02 || q_a[1] !== 8'hAB) begin
      errors++;
      $display("FAIL midreset_refresh: got %s, required 02 AB", q_str(q_a));
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol_a !== 0 || viol_b !== 0) begin
      errors++;
      $display("FAIL start_protocol: violations a=%0d b=%0d, required 0 0", viol_a, viol_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_header();
    test_force();
    test_coalesce();
    test_busy_hold();
    test_ack_timeout();
    test_reset_midframe();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised value-change framer that streams a WIDTH-bit status word out through the existing `uart_tx` byte transmitter. It replaces the hand-coded two-byte counter dump in the lab top-levels. It supports arbitrary word width, an optional sync header byte, forced retransmission and coalescing of changes that arrive mid-frame, with an overrun flag. It sits between the monitored logic (e.g. `counter.cnt`) and `uart_tx`, and connects directly to `tx_start`/`tx_data`/`tx_busy`.

## Interface
- `WIDTH`, default 10: width of the monitored word, 1..32.
- `HEADER_EN`, default 0: when 1, each frame is prefixed with `HEADER`.
- `HEADER`, default 8'hA5: sync byte value.
- `ACK_TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after a `tx_start` pulse; 1..255.
- Derived, not overridable: `NBYTES = (WIDTH+7)/8`; `FRAME_LEN = NBYTES + HEADER_EN`.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `value`  in  WIDTH: monitored word; synchronous to `clk`.
- `force`  in  1: single-cycle request to send `value` even if unchanged.
- `tx_busy`  in  1: busy flag from `uart_tx`.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8: byte to transmit; valid while `tx_start` is 1.
- `busy`  out  1: high while a frame is in progress (state != IDLE).
- `overrun`  out  1: sticky flag; set when a value change is superseded before it is sent; cleared only by `rst`.

## Operation
- Registers:
  - `snap[WIDTH-1:0]`: word being sent.
  - `last_sent`: `snap` of the last completed frame.
  - `value_q`: `value` delayed by one cycle.
  - `chg_pend`: a change was seen during the current frame.
  - `idx`: byte index, range 0..FRAME_LEN-1.
- Trigger: `(value != last_sent) | force`, evaluated only in IDLE. A `force` pulse outside IDLE is ignored.
- Byte order:
  - Header first, if enabled.
  - Then `{pad, snap}` MSB byte first, with the pad zero-filled to NBYTES*8 bits.
  - Example: WIDTH=10, snap=0x2AB gives 0x02, 0xAB.
- FSM:
  - IDLE: on trigger, capture `snap <= value`, `idx <= 0`, `chg_pend <= 0`, go to START.
  - START: if `!tx_busy`, drive `tx_start <= 1`, `tx_data <= byte[idx]`, clear the timeout counter, go to ACK. Otherwise hold.
  - ACK: `tx_start <= 0`. Go to DRAIN when `tx_busy == 1`, or when the timeout counter reaches ACK_TIMEOUT (treated as accepted).
  - DRAIN: when `!tx_busy`:
    - If `idx == FRAME_LEN-1`: `last_sent <= snap`, go to IDLE.
    - Otherwise `idx <= idx+1`, go to START.
- Coalescing:
  - While `busy` and `value != value_q`:
    - If `chg_pend` is already 1, set `overrun <= 1`.
    - Set `chg_pend <= 1`.
  - The latest value is sent automatically: on returning to IDLE, `value != last_sent` retriggers.
  - A change that returns to `snap` before frame end causes no further frame.
- Reset:
  - `rst` aborts any frame immediately: state IDLE, `tx_start=0`.
  - A byte already accepted by `uart_tx` completes on its own; no partial-frame recovery.
- Reset values:
  - `tx_start=0`, `tx_data=8'h00`, `busy=0`, `overrun=0`.
  - `last_sent=0`, `value_q=0`, `snap=0`, `idx=0`, `chg_pend=0`.
  - `value==0` after reset sends nothing until it changes or `force` is pulsed.

## Timing
- `value` changes before edge E0 (in IDLE): leaves IDLE at E0. With `tx_busy` low, `tx_start`=1 from E1 to E2, with `tx_data`=byte0.
- Latency from trigger to first `tx_start` is 1 cycle after capture, or more while `tx_busy` is high.
- `tx_start` is never high for 2 consecutive cycles and is never asserted while `tx_busy` is 1.
- After `tx_busy` falls at the end of byte k, `tx_start` for byte k+1 rises 2 edges later (DRAIN→START, START→ACK).
- Frame-to-frame: `busy` drops for at least 1 cycle (IDLE) between frames.
- `overrun` is set on the edge that samples the second mid-frame change.

## Test plan
- WIDTH=10, HEADER_EN=0, `uart_tx` model busy for 20 cycles per byte; `value` 0→0x2AB → bytes 0x02, 0xAB, then `busy`=0 and no further `tx_start`.
- HEADER_EN=1, WIDTH=24, `value`=0x123456 → 0xA5, 0x12, 0x34, 0x56; `overrun`=0.
- During the first byte of the 0x2AB frame, step `value` 0x001→0x002→0x003 → frame 0x02/0xAB completes, then frame 0x00/0x03 follows; 0x001 and 0x002 are never sent; `overrun`=1.
- `value` held at 0x2AB after its frame, then a `force` pulse → 0x02, 0xAB resent. A `force` pulse mid-frame → no extra frame.
- Hold `tx_busy`=1 before the trigger → `tx_start` stays 0 until release. A model that never raises `tx_busy` → the timeout advances the frame in ACK_TIMEOUT cycles per byte.
- Assert `rst` for 1 cycle in DRAIN of byte 0 → `busy`=0, `tx_start`=0, `overrun`=0 next cycle. With `value`=0x2AB still applied, a new full frame (0x02, 0xAB) starts.
